packet_assembler_buffered: RTL and testbench

Parametrised successor of the data-island packet assembler. It accepts complete packets (24-bit header plus SUB_COUNT 56-bit subpackets) over a valid/ready handshake into a one-entry staging buffer. It emits each packet as BCH-coded 2*SUB_COUNT+1 bits per pixel clock across a 32-cycle slot. When no packet is available it sends a null packet or stays silent, and it aborts cleanly when a data island is truncated. It sits between the packet generators/arbiter and the TERC4 channel encoders.

---
 rtl/packet_assembler_buffered.sv | 133 +++++++++++++
 tb/tb_packet_assembler_buffered.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_assembler_buffered.sv
// packet_assembler_buffered: one-entry staged data-island packet assembler
// with per-codeword BCH parity, null-packet fill and truncated-island abort.
module packet_assembler_buffered #(
  parameter int         SUB_COUNT     = 4,
  parameter logic [7:0] ECC_POLY      = 8'h83,
  parameter bit         NULL_ON_EMPTY = 1'b1
) (
  input  logic                    clk_pixel,
  input  logic                    reset,
  input  logic                    data_island_period,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [23:0]             in_header,
  input  logic [SUB_COUNT*56-1:0] in_sub,
  output logic [2*SUB_COUNT:0]    packet_data,
  output logic                    packet_enable,
  output logic                    underflow,
  output logic                    aborted
);
  localparam int SW = SUB_COUNT * 56;

  function automatic logic [7:0] ecc_step(
    input logic [7:0] e,
    input logic       b
  );
    return (e[0] ^ b) ? ((e >> 1) ^ ECC_POLY) : (e >> 1);
  endfunction

  logic [4:0]    counter;
  logic [7:0]    hdr_par;
  logic [7:0]    hdr_par_nx;
  logic [7:0]    sub_par    [SUB_COUNT];
  logic [7:0]    sub_par_nx [SUB_COUNT];
  logic [63:0]   sub_code   [SUB_COUNT];
  logic [31:0]   hdr_code;
  logic [23:0]   stage_hdr;
  logic [SW-1:0] stage_sub;
  logic          stage_valid;
  logic [23:0]   act_hdr;
  logic [SW-1:0] act_sub;
  logic          active_fresh;

  logic done;
  logic abort_c;
  logic slot_start;
  logic load;
  logic wr;
  logic par_clr;

  assign done       = data_island_period && (counter == 5'd31);
  assign abort_c    = !data_island_period && (counter != 5'd0);
  assign slot_start = data_island_period && (counter == 5'd0);
  assign load       = stage_valid
                    && (!active_fresh || done || abort_c)
                    && (!data_island_period || done);
  assign wr         = in_valid && !stage_valid;
  assign par_clr    = !data_island_period || done;

  assign in_ready      = !stage_valid;
  assign underflow     = slot_start && !active_fresh;
  assign packet_enable = slot_start && (active_fresh || NULL_ON_EMPTY);
  assign aborted       = abort_c;

  always_comb begin
    hdr_code = {hdr_par, act_hdr};
    for (int i = 0; i < SUB_COUNT; i++) begin
      sub_code[i] = {sub_par[i], act_sub[i*56 +: 56]};
    end
  end

  // parity accumulates over the data bits already sent this slot
  always_comb begin
    hdr_par_nx = hdr_par;
    if (par_clr) begin
      hdr_par_nx = '0;
    end else if (counter < 5'd24) begin
      hdr_par_nx = ecc_step(hdr_par, hdr_code[counter]);
    end
    for (int i = 0; i < SUB_COUNT; i++) begin
      sub_par_nx[i] = sub_par[i];
      if (par_clr) begin
        sub_par_nx[i] = '0;
      end else if (counter < 5'd28) begin
        sub_par_nx[i] = ecc_step(
          ecc_step(sub_par[i], sub_code[i][{counter, 1'b0}]),
          sub_code[i][{counter, 1'b1}]);
      end
    end
  end

  always_comb begin
    packet_data    = '0;
    packet_data[0] = hdr_code[counter];
    for (int i = 0; i < SUB_COUNT; i++) begin
      packet_data[i+1]           = sub_code[i][{counter, 1'b0}];
      packet_data[SUB_COUNT+1+i] = sub_code[i][{counter, 1'b1}];
    end
  end

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      counter      <= '0;
      hdr_par      <= '0;
      for (int i = 0; i < SUB_COUNT; i++) sub_par[i] <= '0;
      stage_hdr    <= '0;
      stage_sub    <= '0;
      stage_valid  <= 1'b0;
      act_hdr      <= '0;
      act_sub      <= '0;
      active_fresh <= 1'b0;
    end else begin
      counter <= data_island_period ? counter + 5'd1 : 5'd0;
      hdr_par <= hdr_par_nx;
      for (int i = 0; i < SUB_COUNT; i++) sub_par[i] <= sub_par_nx[i];
      if (load) begin
        act_hdr      <= stage_hdr;
        act_sub      <= stage_sub;
        active_fresh <= 1'b1;
        stage_valid  <= 1'b0;
      end else if (done || abort_c) begin
        act_hdr      <= '0;
        act_sub      <= '0;
        active_fresh <= 1'b0;
      end
      if (wr) begin
        stage_hdr   <= in_header;
        stage_sub   <= in_sub;
        stage_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_packet_assembler_buffered.sv
// Randomised bench for packet_assembler_buffered against a slot-level model
// with full-codeword BCH reference; two instances (4 subs/null, 2 subs/silent).
module tb_packet_assembler_buffered;
  logic         clk_pixel = 1'b0;
  logic         reset     = 1'b0;
  logic         dip       = 1'b0;
  logic         in_valid  = 1'b0;
  logic [23:0]  in_header = '0;
  logic [223:0] in_sub    = '0;

  logic       in_ready_a, in_ready_b;
  logic [8:0] pd_a;
  logic [4:0] pd_b;
  logic       pe_a, pe_b, uf_a, uf_b, ab_a, ab_b;

  int vectors     = 0;
  int miscompares = 0;
  bit checking    = 1'b0;

  always #5 clk_pixel = ~clk_pixel;

  packet_assembler_buffered #(
    .SUB_COUNT(4), .ECC_POLY(8'h83), .NULL_ON_EMPTY(1'b1)
  ) dut_a (
    .clk_pixel(clk_pixel), .reset(reset),
    .data_island_period(dip),
    .in_valid(in_valid), .in_ready(in_ready_a),
    .in_header(in_header), .in_sub(in_sub),
    .packet_data(pd_a), .packet_enable(pe_a),
    .underflow(uf_a), .aborted(ab_a)
  );

  packet_assembler_buffered #(
    .SUB_COUNT(2), .ECC_POLY(8'h83), .NULL_ON_EMPTY(1'b0)
  ) dut_b (
    .clk_pixel(clk_pixel), .reset(reset),
    .data_island_period(dip),
    .in_valid(in_valid), .in_ready(in_ready_b),
    .in_header(in_header), .in_sub(in_sub[111:0]),
    .packet_data(pd_b), .packet_enable(pe_b),
    .underflow(uf_b), .aborted(ab_b)
  );

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s got %h want %h at %0t", nm, got, want, $time);
    end
  endtask

  function automatic logic [7:0] ecc(input logic [63:0] v, input int n);
    logic [7:0] e;
    e = '0;
    for (int k = 0; k < n; k++)
      e = (e[0] ^ v[k]) ? ((e >> 1) ^ 8'h83) : (e >> 1);
    return e;
  endfunction

  // whole-packet codewords, indexed by slot cycle
  function automatic logic [16:0] exp_pd(input logic [23:0] h,
    input logic [223:0] s, input int sc, input int c);
    logic [16:0] r;
    logic [31:0] ch;
    logic [63:0] cs;
    logic [55:0] sb;
    r  = '0;
    ch = {ecc({40'd0, h}, 24), h};
    r[0] = ch[c];
    for (int i = 0; i < sc; i++) begin
      sb = s[i*56 +: 56];
      cs = {ecc({8'd0, sb}, 56), sb};
      r[i+1]    = cs[2*c];
      r[sc+1+i] = cs[2*c+1];
    end
    return r;
  endfunction

  int           m_cnt   = 0;
  bit           m_sv    = 1'b0;
  bit           m_fresh = 1'b0;
  logic [23:0]  m_sh = '0, m_ah = '0;
  logic [223:0] m_ss = '0, m_as = '0;

  always @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      m_cnt = 0; m_sv = 0; m_fresh = 0;
      m_sh = '0; m_ss = '0; m_ah = '0; m_as = '0;
    end else begin
      bit done, abrt, sv0;
      done = dip && m_cnt == 31;
      abrt = !dip && m_cnt != 0;
      sv0  = m_sv;
      if (m_sv && (!m_fresh || done || abrt) && (!dip || m_cnt == 31)) begin
        m_ah = m_sh; m_as = m_ss; m_fresh = 1; m_sv = 0;
      end else if (done || abrt) begin
        m_ah = '0; m_as = '0; m_fresh = 0;
      end
      if (in_valid && !sv0) begin
        m_sh = in_header; m_ss = in_sub; m_sv = 1;
      end
      m_cnt = dip ? (m_cnt + 1) % 32 : 0;
    end
  end

  logic [16:0] ea, eb;
  always @(negedge clk_pixel) begin
    if (checking) begin
      chk("in_ready_a", in_ready_a, !m_sv);
      chk("in_ready_b", in_ready_b, !m_sv);
      chk("underflow_a", uf_a, dip && m_cnt == 0 && !m_fresh);
      chk("underflow_b", uf_b, dip && m_cnt == 0 && !m_fresh);
      chk("enable_a", pe_a, dip && m_cnt == 0);
      chk("enable_b", pe_b, dip && m_cnt == 0 && m_fresh);
      chk("aborted_a", ab_a, !dip && m_cnt != 0);
      chk("aborted_b", ab_b, !dip && m_cnt != 0);
      if (dip) begin
        ea = exp_pd(m_ah, m_as, 4, m_cnt);
        eb = exp_pd(m_ah, m_as, 2, m_cnt);
        chk("data_a", pd_a, ea[8:0]);
        chk("data_b", pd_b, eb[4:0]);
      end
    end
  end

  task automatic drive(input logic d, input logic v,
                       input logic [23:0] h, input logic [223:0] s);
    @(posedge clk_pixel);
    #1;
    dip = d; in_valid = v; in_header = h; in_sub = s;
  endtask

  function automatic logic [223:0] rsub();
    logic [223:0] r;
    for (int i = 0; i < 7; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  logic [31:0]  cap;
  logic [23:0]  ph [5];
  logic [223:0] ps [5];
  int idle, len, k;

  initial begin
    for (int i = 0; i < 5; i++) begin
      ph[i] = 24'($urandom);
      ps[i] = rsub();
    end
    #1 reset = 1'b1;
    checking = 1'b1;
    repeat (2) @(posedge clk_pixel);
    @(negedge clk_pixel);
    chk("rst_data", pd_a, 0);
    chk("rst_ready", in_ready_a, 1);
    chk("rst_enable", pe_a, 0);
    chk("rst_underflow", uf_a, 0);
    chk("rst_aborted", ab_a, 0);
    @(posedge clk_pixel);
    #1 reset = 1'b0;

    // empty slot: null packet on A, silence on B
    drive(0, 0, 0, 0);
    for (int c = 0; c < 32; c++) begin
      drive(1, 0, 0, 0);
      if (c == 0) begin
        @(negedge clk_pixel);
        chk("null_uf", uf_a, 1);
        chk("null_pe_a", pe_a, 1);
        chk("null_pe_b", pe_b, 0);
      end
    end
    drive(0, 0, 0, 0);

    // header=1, zero subs
    drive(0, 1, 24'h000001, '0);
    drive(0, 0, 0, 0);
    @(negedge clk_pixel);
    chk("wr_ready_drop", in_ready_a, 0);
    drive(0, 0, 0, 0);
    @(negedge clk_pixel);
    chk("load_ready_back", in_ready_a, 1);
    for (int c = 0; c < 32; c++) begin
      drive(1, 0, 0, 0);
      @(negedge clk_pixel);
      cap[c] = pd_a[0];
      chk("hdr1_upper", {23'd0, pd_a[8:1]}, 0);
    end
    chk("hdr1_bch4", cap, 32'h4A000001);
    chk("ecc_pin", ecc(64'h1, 24), 8'h4A);
    drive(0, 0, 0, 0);

    // back-to-back slots, second staged mid-slot, third stalls
    drive(0, 1, ph[0], ps[0]);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    for (int c = 0; c < 64; c++) begin
      drive(1, (c == 2) || (c >= 5 && c <= 33),
            (c == 2) ? ph[1] : ph[2], (c == 2) ? ps[1] : ps[2]);
      @(negedge clk_pixel);
      if (c == 20) chk("stall_ready", in_ready_a, 0);
      if (c == 32) begin
        chk("slot2_ready", in_ready_a, 1);
        chk("slot2_pe", pe_a, 1);
        chk("slot2_uf", uf_a, 0);
      end
    end

    // truncated island with a packet staged during it
    for (int c = 0; c < 11; c++) drive(1, c == 3, ph[3], ps[3]);
    drive(0, 0, 0, 0);
    @(negedge clk_pixel);
    chk("abort_pulse", ab_a, 1);
    drive(0, 0, 0, 0);
    @(negedge clk_pixel);
    chk("abort_once", ab_a, 0);
    for (int c = 0; c < 32; c++) begin
      drive(1, 0, 0, 0);
      if (c == 0) begin
        @(negedge clk_pixel);
        chk("after_abort_uf", uf_a, 0);
      end
    end
    drive(0, 0, 0, 0);
    for (int c = 0; c < 32; c++) drive(1, 0, 0, 0);

    for (int it = 0; it < 40; it++) begin
      idle = $urandom_range(1, 4);
      k    = $urandom_range(0, 3);
      len  = (k == 0) ? 32 : (k == 1) ? 64 : (k == 2) ? 96
           : $urandom_range(1, 40);
      for (int i = 0; i < idle; i++)
        drive(0, $urandom_range(0, 3) == 0, 24'($urandom), rsub());
      for (int i = 0; i < len; i++)
        drive(1, $urandom_range(0, 2) == 0, 24'($urandom), rsub());
    end
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);

    // reset mid-slot with a staged packet
    drive(0, 1, ph[4], ps[4]);
    drive(0, 0, 0, 0);
    drive(0, 1, ph[0], ps[0]);
    for (int c = 0; c < 16; c++) drive(1, 0, 0, 0);
    #2;
    reset = 1'b1;
    dip   = 1'b0;
    #1;
    chk("mid_rst_ready", in_ready_a, 1);
    chk("mid_rst_pe", pe_a, 0);
    chk("mid_rst_uf", uf_a, 0);
    chk("mid_rst_ab", ab_a, 0);
    chk("mid_rst_data", pd_a, 0);
    repeat (2) @(posedge clk_pixel);
    #1 reset = 1'b0;
    drive(0, 0, 0, 0);
    for (int c = 0; c < 32; c++) begin
      drive(1, 0, 0, 0);
      if (c == 0) begin
        @(negedge clk_pixel);
        chk("post_rst_uf", uf_a, 1);
      end
    end
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    @(negedge clk_pixel);
    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
